// File: rtl/uop_pkg.sv
// Shared micro-op types and default queue geometry for the decode/rename boundary.
//   INSTR_Q_DEPTH : default issue-queue entry count
//   INSTR_Q_WIDTH : default enqueue/dequeue lanes per cycle
//   uop_insn      : one decoded micro-op; .valid is rewritten by the queue on the way out
package uop_pkg;

    localparam int INSTR_Q_DEPTH = 32;
    localparam int INSTR_Q_WIDTH = 4;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } uop_insn;

endpackage

// File: rtl/uop_issue_queue_if.sv
// Handshake bundle between decode (producer), rename/dispatch (consumer) and
// the uop issue queue.
//   master : decode/dispatch side; drives flush, enqueue lanes and pop count
//   slave  : the queue; drives ready, dequeue view and status
interface uop_issue_queue_if #(
    parameter int WIDTH = uop_pkg::INSTR_Q_WIDTH,
    parameter int DEPTH = uop_pkg::INSTR_Q_DEPTH
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int OW = $clog2(DEPTH + 1);

    logic                              flush_in;
    logic [WIDTH-1:0]                  enq_valid_in;
    uop_pkg::uop_insn [WIDTH-1:0]      enq_uop_in;
    logic                              enq_ready_out;
    uop_pkg::uop_insn [WIDTH-1:0]      deq_uop_out;
    logic [WIDTH-1:0]                  deq_valid_out;
    logic [CW-1:0]                     deq_count_in;
    logic [OW-1:0]                     count_out;
    logic                              empty_out;
    logic                              full_out;
    logic                              deq_err_out;

    modport master (
        output flush_in, enq_valid_in, enq_uop_in, deq_count_in,
        input  enq_ready_out, deq_uop_out, deq_valid_out, count_out,
               empty_out, full_out, deq_err_out
    );

    modport slave (
        input  flush_in, enq_valid_in, enq_uop_in, deq_count_in,
        output enq_ready_out, deq_uop_out, deq_valid_out, count_out,
               empty_out, full_out, deq_err_out
    );

endinterface

// File: rtl/uop_issue_queue.sv
// Multi-wide circular uop FIFO between decode and rename/dispatch.
// Accepts up to WIDTH uops per cycle from a sparse lane mask (compacted in
// lane order), presents the WIDTH oldest entries, and supports a one-cycle
// flush.
//   clk_in   : clock, rising edge
//   rst_N_in : asynchronous active-low reset
//   iq       : uop_issue_queue_if slave (enqueue lanes, dequeue view,
//              pop count, flush, occupancy/empty/full, sticky pop error)
module uop_issue_queue #(
    parameter int DEPTH = uop_pkg::INSTR_Q_DEPTH,
    parameter int WIDTH = uop_pkg::INSTR_Q_WIDTH
) (
    input  logic            clk_in,
    input  logic            rst_N_in,
    uop_issue_queue_if.slave iq
);
    import uop_pkg::*;

    localparam int CW = $clog2(WIDTH + 1);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    uop_insn        mem [DEPTH];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [OW-1:0]  cnt;
    logic           err;

    logic           enq_ready;
    logic           enq_fire;
    logic [CW-1:0]  n_enq;
    logic [CW-1:0]  n_enq_eff;
    logic [PW-1:0]  wr_idx [WIDTH];
    logic [CW-1:0]  live;
    logic [CW-1:0]  n_deq;
    logic           over_pop;
    logic [OW-1:0]  cnt_next;
    logic [OW-1:0]  space;

    logic [WIDTH-1:0]    deq_valid;
    uop_insn [WIDTH-1:0] deq_uop;

    // Ready looks only at registered occupancy so the producer never sees a
    // combinational path from its own valids or from the consumer's pop.
    always_comb begin
        space     = OW'(DEPTH) - cnt;
        enq_ready = (space >= OW'(WIDTH));
        enq_fire  = enq_ready && !iq.flush_in;
    end

    // Compaction: each valid lane lands at tail + (number of valid lanes
    // below it), so the k-th set lane goes to tail+k.
    always_comb begin
        n_enq = '0;
        for (int i = 0; i < WIDTH; i++) begin
            wr_idx[i] = tail + PW'(n_enq);
            if (iq.enq_valid_in[i]) begin
                n_enq = n_enq + CW'(1);
            end
        end
        n_enq_eff = enq_fire ? n_enq : '0;
    end

    // Pop is clamped to the lanes actually shown; asking for more is flagged.
    always_comb begin
        if (cnt >= OW'(WIDTH)) begin
            live = CW'(WIDTH);
        end else begin
            live = CW'(cnt);
        end
        over_pop = (iq.deq_count_in > live);
        n_deq    = over_pop ? live : iq.deq_count_in;
        cnt_next = cnt + OW'(n_enq_eff) - OW'(n_deq);
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            err  <= 1'b0;
        end else if (iq.flush_in) begin
            // Flush wins over everything this cycle; err deliberately survives.
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            tail <= tail + PW'(n_enq_eff);
            head <= head + PW'(n_deq);
            cnt  <= cnt_next;
            if (over_pop) begin
                err <= 1'b1;
            end
        end
    end

    // Payload storage has no reset; liveness is tracked purely by cnt.
    always_ff @(posedge clk_in) begin
        if (enq_fire) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (iq.enq_valid_in[i]) begin
                    mem[wr_idx[i]] <= iq.enq_uop_in[i];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            deq_valid[i]       = (cnt > OW'(i));
            deq_uop[i]         = mem[head + PW'(i)];
            deq_uop[i].valid   = deq_valid[i];
        end
    end

    assign iq.enq_ready_out = enq_ready;
    assign iq.deq_valid_out = deq_valid;
    assign iq.deq_uop_out   = deq_uop;
    assign iq.count_out     = cnt;
    assign iq.empty_out     = (cnt == '0);
    assign iq.full_out      = (cnt == OW'(DEPTH));
    assign iq.deq_err_out   = err;

endmodule

// File: tb/tb_uop_issue_queue.sv
module tb_uop_issue_queue;
    import uop_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    uop_issue_queue_if #(.WIDTH(4), .DEPTH(32)) qif ();

    uop_issue_queue #(.DEPTH(32), .WIDTH(4)) dut (
        .clk_in   (clk),
        .rst_N_in (rst_n),
        .iq       (qif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic uop_insn mk(input logic [31:0] pc);
        uop_insn u;
        u       = '0;
        u.valid = 1'b1;
        u.pc    = pc;
        u.insn  = ~pc;
        u.rd    = pc[4:0];
        return u;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        qif.flush_in     = 1'b0;
        qif.enq_valid_in = '0;
        qif.deq_count_in = '0;
        for (int i = 0; i < 4; i++) qif.enq_uop_in[i] = mk(32'hDEAD_0000 + i);
    endtask

    task automatic enq_group(input logic [3:0] mask, input logic [31:0] pc0);
        qif.enq_valid_in = mask;
        for (int i = 0; i < 4; i++) qif.enq_uop_in[i] = mk(pc0 + i);
        tick();
        qif.enq_valid_in = '0;
    endtask

    task automatic pop(input int n);
        qif.deq_count_in = 3'(n);
        tick();
        qif.deq_count_in = '0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (qif.enq_ready_out !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", qif.enq_ready_out); end
        n_cmp++; if (qif.deq_valid_out !== 4'b0000) begin n_bad++; $display("FAIL reset_deq_valid: got %b want 0000", qif.deq_valid_out); end
        n_cmp++; if (qif.count_out !== 6'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", qif.count_out); end
        n_cmp++; if (qif.empty_out !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", qif.empty_out); end
        n_cmp++; if (qif.full_out !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", qif.full_out); end
        n_cmp++; if (qif.deq_err_out !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", qif.deq_err_out); end
        n_cmp++; if (qif.deq_uop_out[0].valid !== 1'b0) begin n_bad++; $display("FAIL reset_uop_valid: got %b want 0", qif.deq_uop_out[0].valid); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_group;
        enq_group(4'b1111, 32'h10);
        n_cmp++; if (qif.count_out !== 6'd4) begin n_bad++; $display("FAIL grp_count: got %0d want 4", qif.count_out); end
        n_cmp++; if (qif.deq_valid_out !== 4'b1111) begin n_bad++; $display("FAIL grp_valid: got %b want 1111", qif.deq_valid_out); end
        n_cmp++; if (qif.deq_uop_out[0].pc !== 32'h10) begin n_bad++; $display("FAIL grp_pc0: got %h want 10", qif.deq_uop_out[0].pc); end
        n_cmp++; if (qif.deq_uop_out[3].pc !== 32'h13) begin n_bad++; $display("FAIL grp_pc3: got %h want 13", qif.deq_uop_out[3].pc); end
        n_cmp++; if (qif.deq_uop_out[2].valid !== 1'b1) begin n_bad++; $display("FAIL grp_uop_valid: got %b want 1", qif.deq_uop_out[2].valid); end
        n_cmp++; if (qif.empty_out !== 1'b0) begin n_bad++; $display("FAIL grp_empty: got %b want 0", qif.empty_out); end
        pop(4);
        n_cmp++; if (qif.count_out !== 6'd0) begin n_bad++; $display("FAIL grp_drain: got %0d want 0", qif.count_out); end
        n_cmp++; if (qif.empty_out !== 1'b1) begin n_bad++; $display("FAIL grp_drain_empty: got %b want 1", qif.empty_out); end
    endtask

    task automatic test_sparse;
        qif.enq_valid_in  = 4'b1010;
        qif.enq_uop_in[0] = mk(32'hBAD0);
        qif.enq_uop_in[1] = mk(32'hA0);
        qif.enq_uop_in[2] = mk(32'hBAD2);
        qif.enq_uop_in[3] = mk(32'hA1);
        tick();
        qif.enq_valid_in = '0;
        n_cmp++; if (qif.count_out !== 6'd2) begin n_bad++; $display("FAIL sparse_count: got %0d want 2", qif.count_out); end
        n_cmp++; if (qif.deq_valid_out !== 4'b0011) begin n_bad++; $display("FAIL sparse_valid: got %b want 0011", qif.deq_valid_out); end
        n_cmp++; if (qif.deq_uop_out[0].pc !== 32'hA0) begin n_bad++; $display("FAIL sparse_pc0: got %h want a0", qif.deq_uop_out[0].pc); end
        n_cmp++; if (qif.deq_uop_out[1].pc !== 32'hA1) begin n_bad++; $display("FAIL sparse_pc1: got %h want a1", qif.deq_uop_out[1].pc); end
        n_cmp++; if (qif.deq_uop_out[2].valid !== 1'b0) begin n_bad++; $display("FAIL sparse_lane2_valid: got %b want 0", qif.deq_uop_out[2].valid); end
        pop(2);
        n_cmp++; if (qif.count_out !== 6'd0) begin n_bad++; $display("FAIL sparse_drain: got %0d want 0", qif.count_out); end
    endtask

    task automatic test_fill_ready;
        for (int g = 0; g < 7; g++) enq_group(4'b1111, 32'h100 + 4 * g);
        enq_group(4'b0001, 32'h11C);
        n_cmp++; if (qif.count_out !== 6'd29) begin n_bad++; $display("FAIL fill_count: got %0d want 29", qif.count_out); end
        n_cmp++; if (qif.enq_ready_out !== 1'b0) begin n_bad++; $display("FAIL fill_ready: got %b want 0", qif.enq_ready_out); end
        enq_group(4'b1111, 32'h900);
        n_cmp++; if (qif.count_out !== 6'd29) begin n_bad++; $display("FAIL fill_reject_count: got %0d want 29", qif.count_out); end
        n_cmp++; if (qif.deq_uop_out[0].pc !== 32'h100) begin n_bad++; $display("FAIL fill_head_pc: got %h want 100", qif.deq_uop_out[0].pc); end
        pop(1);
        n_cmp++; if (qif.count_out !== 6'd28) begin n_bad++; $display("FAIL pop1_count: got %0d want 28", qif.count_out); end
        n_cmp++; if (qif.enq_ready_out !== 1'b1) begin n_bad++; $display("FAIL pop1_ready: got %b want 1", qif.enq_ready_out); end
        qif.deq_count_in = 3'd4;
        enq_group(4'b1111, 32'h11D);
        qif.deq_count_in = '0;
        n_cmp++; if (qif.count_out !== 6'd28) begin n_bad++; $display("FAIL popenq_count: got %0d want 28", qif.count_out); end
        n_cmp++; if (qif.deq_uop_out[0].pc !== 32'h105) begin n_bad++; $display("FAIL popenq_head_pc: got %h want 105", qif.deq_uop_out[0].pc); end
        enq_group(4'b1111, 32'h121);
        n_cmp++; if (qif.full_out !== 1'b1) begin n_bad++; $display("FAIL full_flag: got %b want 1", qif.full_out); end
        n_cmp++; if (qif.enq_ready_out !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b want 0", qif.enq_ready_out); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (qif.deq_uop_out[0].pc !== 32'h105 + 4 * k) begin n_bad++; $display("FAIL drain_pc0[%0d]: got %h want %h", k, qif.deq_uop_out[0].pc, 32'h105 + 4 * k); end
            n_cmp++; if (qif.deq_uop_out[3].pc !== 32'h108 + 4 * k) begin n_bad++; $display("FAIL drain_pc3[%0d]: got %h want %h", k, qif.deq_uop_out[3].pc, 32'h108 + 4 * k); end
            pop(4);
        end
        n_cmp++; if (qif.empty_out !== 1'b1) begin n_bad++; $display("FAIL drain_empty: got %b want 1", qif.empty_out); end
    endtask

    // Head index here is 5 and keeps moving, so many groups straddle 31->0.
    task automatic test_wrap;
        int          cnt_m;
        int          pops;
        logic        ready_m;
        logic [31:0] exp_pc;
        logic [31:0] next_pc;
        cnt_m   = 0;
        exp_pc  = 32'h1000;
        next_pc = 32'h1000;
        for (int c = 0; c < 80; c++) begin
            ready_m = ((32 - cnt_m) >= 4);
            pops    = (cnt_m < 3) ? cnt_m : 3;
            n_cmp++; if (qif.count_out !== 6'(cnt_m)) begin n_bad++; $display("FAIL wrap_count[%0d]: got %0d want %0d", c, qif.count_out, cnt_m); end
            n_cmp++; if (qif.enq_ready_out !== ready_m) begin n_bad++; $display("FAIL wrap_ready[%0d]: got %b want %b", c, qif.enq_ready_out, ready_m); end
            for (int j = 0; j < pops; j++) begin
                n_cmp++; if (qif.deq_uop_out[j].pc !== exp_pc + j) begin n_bad++; $display("FAIL wrap_pc[%0d.%0d]: got %h want %h", c, j, qif.deq_uop_out[j].pc, exp_pc + j); end
            end
            qif.deq_count_in = 3'(pops);
            if (c < 60 && ready_m) begin
                enq_group(4'b1111, next_pc);
                next_pc = next_pc + 4;
                cnt_m   = cnt_m + 4;
            end else begin
                tick();
            end
            qif.deq_count_in = '0;
            cnt_m  = cnt_m - pops;
            exp_pc = exp_pc + pops;
        end
        n_cmp++; if (qif.count_out !== 6'd0) begin n_bad++; $display("FAIL wrap_final_count: got %0d want 0", qif.count_out); end
        n_cmp++; if (exp_pc !== next_pc) begin n_bad++; $display("FAIL wrap_all_popped: popped up to %h want %h", exp_pc, next_pc); end
    endtask

    task automatic test_flush;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        enq_group(4'b1111, 32'h200);
        enq_group(4'b1111, 32'h204);
        enq_group(4'b0011, 32'h208);
        n_cmp++; if (qif.count_out !== 6'd10) begin n_bad++; $display("FAIL flush_pre_count: got %0d want 10", qif.count_out); end
        qif.flush_in     = 1'b1;
        qif.deq_count_in = 3'd2;
        enq_group(4'b1111, 32'h300);
        qif.flush_in     = 1'b0;
        qif.deq_count_in = '0;
        n_cmp++; if (qif.count_out !== 6'd0) begin n_bad++; $display("FAIL flush_count: got %0d want 0", qif.count_out); end
        n_cmp++; if (qif.empty_out !== 1'b1) begin n_bad++; $display("FAIL flush_empty: got %b want 1", qif.empty_out); end
        n_cmp++; if (qif.deq_valid_out !== 4'b0000) begin n_bad++; $display("FAIL flush_valid: got %b want 0000", qif.deq_valid_out); end
        n_cmp++; if (qif.deq_err_out !== 1'b0) begin n_bad++; $display("FAIL flush_err: got %b want 0", qif.deq_err_out); end
        enq_group(4'b0100, 32'h75);
        n_cmp++; if (qif.deq_uop_out[0].pc !== 32'h77) begin n_bad++; $display("FAIL post_flush_pc: got %h want 77", qif.deq_uop_out[0].pc); end
        n_cmp++; if (qif.count_out !== 6'd1) begin n_bad++; $display("FAIL post_flush_count: got %0d want 1", qif.count_out); end
    endtask

    task automatic test_deq_err;
        pop(3);
        n_cmp++; if (qif.count_out !== 6'd0) begin n_bad++; $display("FAIL err_count: got %0d want 0", qif.count_out); end
        n_cmp++; if (qif.deq_err_out !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", qif.deq_err_out); end
        enq_group(4'b1111, 32'h400);
        pop(4);
        n_cmp++; if (qif.deq_err_out !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", qif.deq_err_out); end
        n_cmp++; if (qif.count_out !== 6'd0) begin n_bad++; $display("FAIL err_traffic_count: got %0d want 0", qif.count_out); end
        qif.flush_in = 1'b1;
        tick();
        qif.flush_in = 1'b0;
        n_cmp++; if (qif.deq_err_out !== 1'b1) begin n_bad++; $display("FAIL err_survives_flush: got %b want 1", qif.deq_err_out); end
        enq_group(4'b1111, 32'h500);
        enq_group(4'b1111, 32'h504);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (qif.count_out !== 6'd0) begin n_bad++; $display("FAIL async_rst_count: got %0d want 0", qif.count_out); end
        n_cmp++; if (qif.deq_valid_out !== 4'b0000) begin n_bad++; $display("FAIL async_rst_valid: got %b want 0000", qif.deq_valid_out); end
        n_cmp++; if (qif.deq_err_out !== 1'b0) begin n_bad++; $display("FAIL async_rst_err: got %b want 0", qif.deq_err_out); end
        n_cmp++; if (qif.empty_out !== 1'b1) begin n_bad++; $display("FAIL async_rst_empty: got %b want 1", qif.empty_out); end
        n_cmp++; if (qif.enq_ready_out !== 1'b1) begin n_bad++; $display("FAIL async_rst_ready: got %b want 1", qif.enq_ready_out); end
        n_cmp++; if (qif.deq_uop_out[0].valid !== 1'b0) begin n_bad++; $display("FAIL async_rst_uop_valid: got %b want 0", qif.deq_uop_out[0].valid); end
        tick();
        rst_n = 1'b1;
        enq_group(4'b0010, 32'h600);
        n_cmp++; if (qif.deq_uop_out[0].pc !== 32'h601) begin n_bad++; $display("FAIL post_rst_pc: got %h want 601", qif.deq_uop_out[0].pc); end
        n_cmp++; if (qif.deq_err_out !== 1'b0) begin n_bad++; $display("FAIL post_rst_err: got %b want 0", qif.deq_err_out); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_full_group();
        test_sparse();
        test_fill_ready();
        test_wrap();
        test_flush();
        test_deq_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
